serial_subtractor: RTL and testbench

- Multi-cycle digit-serial subtractor. Computes {borrow, difference} = i_a - i_b - i_borrow_in over N operands.
- Processes W bits per clock, least-significant slice first, rippling the borrow between slices.
- Accepts operands and returns results through valid/ready handshakes.
- Sits beside the combinational adder in the datapath, for area-constrained wide subtraction and compare.

---
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned subtractor.
// Computes {borrow, difference} = a - b - borrow_in over N bits, W bits per
// clock, least-significant slice first. Operands enter and results leave
// through valid/ready handshakes; the result registers only update once the
// whole difference is assembled, so partial slices are never visible.
module serial_subtractor #(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_borrow_in,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_d,
    output logic         o_borrow_out,
    output logic         o_zero
);

    // Guard the division so a bad W reports the error below instead of
    // failing on a divide-by-zero first.
    localparam int SLICES = (W >= 1) ? (N / W) : 1;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

    generate
        if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_param
            $error("serial_subtractor: W must divide N and satisfy 1 <= W <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [N-1:0]     diff_q, diff_d;
    logic [N-1:0]     d_q, d_d;
    logic             bo_q, bo_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    // Current slice result; the top bit of the W+1-bit difference is the
    // outgoing borrow (the difference is negative exactly when it is set).
    logic [W:0]   slice_full;
    logic [W-1:0] slice_s;
    logic         slice_b;
    logic [N-1:0] assembled;

    // Slice arithmetic: operands are shifted right each slice, so the
    // active slice always sits in the low W bits.
    always_comb begin
        slice_full = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, borrow_q};
        slice_s    = slice_full[W-1:0];
        slice_b    = slice_full[W];
        // New slice enters from the MSB side; after SLICES shifts slice 0
        // has reached the bottom. Written as a shift of the concatenation
        // so it also covers W == N without an empty part-select.
        assembled  = N'({slice_s, diff_q} >> W);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        d_d      = d_q;
        bo_d     = bo_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    a_d      = i_a;
                    b_d      = i_b;
                    borrow_d = i_borrow_in;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> W;
                b_d      = b_q >> W;
                borrow_d = slice_b;
                diff_d   = assembled;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    d_d     = assembled;
                    bo_d    = slice_b;
                    zero_d  = (assembled == '0);
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready      = (state_q == IDLE) && !i_rst;
    assign o_valid      = valid_q;
    assign o_d          = d_q;
    assign o_borrow_out = bo_q;
    assign o_zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor.
// Four builds (W = 8, 1, 16, 64 with N = 64) run side by side, each with its
// own directed sequence, randomized regression, scoreboard queue and monitor.
module tb_serial_subtractor;

    localparam int N = 64;

    logic clk;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   n_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int WG   = (gi == 0) ? 8 : (gi == 1) ? 1 : (gi == 2) ? 16 : 64;
        localparam int LAT  = N / WG;
        localparam int NOPS = (gi == 0) ? 1000 : 300;
        localparam int KRST = (LAT >= 5) ? 3 : 0;

        logic         rst, vin, rdy, bin, vout, rin, bo, z;
        logic [N-1:0] a, b, d;
        logic         rr_en, fix_rdy;

        logic [N:0]   exp_q[$];
        int           acc_q[$];

        serial_subtractor #(.N(N), .W(WG)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_valid     (vin),
            .o_ready     (rdy),
            .i_a         (a),
            .i_b         (b),
            .i_borrow_in (bin),
            .o_valid     (vout),
            .i_ready     (rin),
            .o_d         (d),
            .o_borrow_out(bo),
            .o_zero      (z)
        );

        // Consumer ready: fixed level or random stalls.
        initial begin
            rin = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                rin = rr_en ? ($urandom_range(0, 3) != 0) : fix_rdy;
            end
        end

        // Monitor: pushes the model result on every accepted operand and
        // compares on every presented result.
        initial begin
            logic [N:0]   e;
            logic [N+1:0] hold;
            bit           seen, busy, after_pop;
            int           nres;
            seen = 0; busy = 0; after_pop = 0; nres = 0; hold = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    exp_q.delete();
                    acc_q.delete();
                    seen = 0; busy = 0; after_pop = 0;
                    chk($sformatf("w%0d_reset_outputs", WG), 128'({vout, rdy, bo, z, d}), 128'(0));
                end else begin
                    if (after_pop) begin
                        chk($sformatf("w%0d_ready_after_result", WG), 128'(rdy), 128'(1));
                        after_pop = 0;
                    end else if (busy && !vout) begin
                        chk($sformatf("w%0d_ready_low_run", WG), 128'(rdy), 128'(0));
                    end
                    if (vout) begin
                        if (!seen) begin
                            if (exp_q.size() == 0) begin
                                chk($sformatf("w%0d_spurious_valid", WG), 128'(vout), 128'(0));
                            end else begin
                                e = exp_q[0];
                                chk($sformatf("w%0d_latency", WG), 128'(cyc - acc_q[0]), 128'(LAT));
                                chk($sformatf("w%0d_result", WG), 128'({bo, d}), 128'(e));
                                chk($sformatf("w%0d_zero", WG), 128'(z), 128'(e[N-1:0] == '0));
                                nres++;
                                $display("[W=%0d] result %0d: d=0x%h borrow=%0b zero=%0b", WG, nres, d, bo, z);
                            end
                            seen = 1;
                            hold = {z, bo, d};
                        end else begin
                            chk($sformatf("w%0d_stall_hold", WG), 128'({z, bo, d}), 128'(hold));
                        end
                        chk($sformatf("w%0d_ready_low_done", WG), 128'(rdy), 128'(0));
                        if (rin) begin
                            if (exp_q.size() > 0) begin
                                void'(exp_q.pop_front());
                                void'(acc_q.pop_front());
                            end
                            seen = 0; busy = 0; after_pop = 1;
                        end
                    end
                    if (vin && rdy) begin
                        exp_q.push_back({1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin});
                        acc_q.push_back(cyc + 1);
                        busy = 1;
                    end
                end
            end
        end

        // Present operands until accepted; call and return at posedge+1.
        task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin);
            int t = 0;
            a = ta; b = tb; bin = tbin; vin = 1'b1;
            while (!rdy && t < 4000) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!rdy) chk($sformatf("w%0d_accept_timeout", WG), 128'(rdy), 128'(1));
            @(posedge clk);
            #1;
            vin = 1'b0;
        endtask

        // Wait for a result, capture it, and wait for its handshake.
        task automatic wait_res(output logic [N+1:0] res);
            int t = 0;
            while (!vout && t < 2000) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!vout) chk($sformatf("w%0d_result_timeout", WG), 128'(vout), 128'(1));
            res = {z, bo, d};
            while (vout && t < 4000) begin
                @(posedge clk);
                #1;
                t++;
            end
        endtask

        task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                              output logic [N+1:0] res);
            issue(ta, tb, tbin);
            wait_res(res);
        endtask

        // Stimulus: directed cases, then randomized regression.
        initial begin
            logic [N+1:0] res, res1;
            logic [N-1:0] sa, sb, ra, rb;
            logic         sbin, rbin;
            logic [N:0]   se;
            int           t;
            rst = 1'b1; vin = 1'b0; a = '0; b = '0; bin = 1'b0;
            rr_en = 1'b0; fix_rdy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;

            run_op(64'd10, 64'd3, 1'b0, res);
            chk($sformatf("w%0d_sub_10_3", WG), 128'(res), 128'({2'b00, 64'd7}));
            run_op(64'd0, 64'd1, 1'b0, res);
            chk($sformatf("w%0d_sub_0_1", WG), 128'(res), 128'({2'b01, {N{1'b1}}}));
            run_op(64'h100, 64'h1, 1'b0, res);
            chk($sformatf("w%0d_sub_100_1", WG), 128'(res), 128'({2'b00, 64'hFF}));
            run_op(64'd5, 64'd5, 1'b0, res);
            chk($sformatf("w%0d_equal_bin0", WG), 128'(res), 128'({2'b10, {N{1'b0}}}));
            run_op(64'd5, 64'd5, 1'b1, res);
            chk($sformatf("w%0d_equal_bin1", WG), 128'(res), 128'({2'b01, {N{1'b1}}}));

            // Backpressure with operand churn during RUN.
            sa = {$urandom(), $urandom()};
            sb = {$urandom(), $urandom()};
            sbin = 1'($urandom_range(0, 1));
            se = {1'b0, sa} - {1'b0, sb} - {{N{1'b0}}, sbin};
            fix_rdy = 1'b0;
            issue(sa, sb, sbin);
            t = 0;
            while (!vout && t < 2000) begin
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
                bin = ~bin;
                vin = ~vin;
                @(posedge clk);
                #1;
                t++;
            end
            vin = 1'b0;
            res1 = {z, bo, d};
            repeat (5) @(posedge clk);
            #1;
            chk($sformatf("w%0d_stall_first", WG), 128'(res1), 128'({(se[N-1:0] == '0), se}));
            chk($sformatf("w%0d_stall_after5", WG), 128'({z, bo, d}), 128'({(se[N-1:0] == '0), se}));
            chk($sformatf("w%0d_stall_valid", WG), 128'(vout), 128'(1));
            fix_rdy = 1'b1;
            t = 0;
            while (vout && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk($sformatf("w%0d_ready_after_done", WG), 128'({vout, rdy}), 128'(2'b01));

            // Asynchronous reset in the middle of an operation.
            run_op(64'd0, 64'd1, 1'b0, res);
            issue({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
            repeat (KRST) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk($sformatf("w%0d_async_reset", WG), 128'({vout, rdy, bo, z, d}), 128'(0));
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            run_op(64'hDEAD_BEEF, 64'hBEEF, 1'b0, res);
            chk($sformatf("w%0d_after_reset", WG), 128'(res), 128'({2'b00, 64'hDEAD_0000}));

            // Randomized regression with random consumer stalls.
            rr_en = 1'b1;
            for (int i = 0; i < NOPS; i++) begin
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
                rbin = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0: rb = ra;
                    1: begin ra = '0; rb = N'($urandom_range(0, 3)); end
                    2: rb = ra + N'(1);
                    3: begin ra = {N{1'b1}}; rb = N'($urandom_range(0, 1)); end
                    default: ;
                endcase
                issue(ra, rb, rbin);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            t = 0;
            while (exp_q.size() != 0 && t < 5000) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk($sformatf("w%0d_drain", WG), 128'(exp_q.size()), 128'(0));
            n_done++;
        end
    end

    initial begin
        while (n_done < 4 && cyc < 95000) @(posedge clk);
        if (n_done < 4) chk("global_timeout", 128'(n_done), 128'(4));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
